// File: rtl/conv1_ofm_writer.sv
// Serialises each conv1 output pixel (DSP_NO channels) into LANES-wide RAM beats at sequential addresses.
// Optional feature macro WR_PARITY_EN: appends an even-parity MSB to every wr_data beat.
module conv1_ofm_writer #(
    parameter int WOUT   = 128,
    parameter int DSP_NO = 64,
    parameter int WIDTH  = 16,
    parameter int LANES  = 8,
    parameter int ADDR_W = $clog2(WOUT * WOUT * (DSP_NO / LANES))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    conv1_sample,
    input  logic                    conv1_finish,
    input  logic [WIDTH-1:0]        ofm [0:DSP_NO-1],
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
`ifdef WR_PARITY_EN
    output logic [LANES*WIDTH:0]    wr_data,
`else
    output logic [LANES*WIDTH-1:0]  wr_data,
`endif
    output logic                    ram_feedback,
    output logic                    done,
    output logic                    overrun,
    output logic                    short_frame
);

    localparam int BEATS  = DSP_NO / LANES;
    localparam int FRAME  = WOUT * WOUT;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PIX_W  = $clog2(FRAME + 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                 state, state_next;
    logic [BEAT_W-1:0]      beat, beat_nx;
    logic [PIX_W-1:0]       pix;
    logic [WIDTH-1:0]       shadow [0:DSP_NO-1];
    logic [LANES*WIDTH-1:0] beat_data;
    logic                   load, last_beat, finish_frame;

    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign beat_nx   = last_beat ? '0 : beat + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next   = state;
        load         = 1'b0;
        finish_frame = 1'b0;
        case (state)
            IDLE: if (conv1_sample) begin
                load       = 1'b1;
                state_next = WRITE;
            end
            WRITE: if (last_beat) begin
                if (pix == PIX_W'(FRAME - 1)) begin
                    finish_frame = 1'b1;
                    state_next   = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Beat 0 comes straight from ofm so it can be registered on the sample edge.
    always_comb begin
        beat_data = '0;
        for (int l = 0; l < LANES; l++)
            beat_data[l*WIDTH +: WIDTH] = load ? ofm[l] : shadow[int'(beat_nx) * LANES + l];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            ram_feedback <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            short_frame  <= 1'b0;
            beat         <= '0;
            pix          <= '0;
            // NOTE: the shadow array is explicitly cleared; it is small enough to live in flops.
            for (int i = 0; i < DSP_NO; i++) shadow[i] <= '0;
        end else begin
            ram_feedback <= finish_frame;
            if (finish_frame) done <= 1'b1;
            if (conv1_sample && state != IDLE) overrun <= 1'b1;
            if (conv1_finish && state == IDLE && pix < PIX_W'(FRAME)) short_frame <= 1'b1;

            if (load) begin
                for (int i = 0; i < DSP_NO; i++) shadow[i] <= ofm[i];
                beat    <= '0;
                wr_en   <= 1'b1;
                wr_addr <= ADDR_W'(pix) * ADDR_W'(BEATS);
`ifdef WR_PARITY_EN
                wr_data <= {^beat_data, beat_data};
`else
                wr_data <= beat_data;
`endif
            end else if (state == WRITE) begin
                if (last_beat) begin
                    wr_en <= 1'b0;
                    beat  <= '0;
                    pix   <= pix + 1'b1;
                end else begin
                    beat    <= beat_nx;
                    wr_addr <= wr_addr + 1'b1;
`ifdef WR_PARITY_EN
                    wr_data <= {^beat_data, beat_data};
`else
                    wr_data <= beat_data;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_conv1_ofm_writer.sv
// Directed self-checking bench for conv1_ofm_writer, built with WOUT=4 so a full frame fits in a short run.
module tb_conv1_ofm_writer;

    localparam int WOUT   = 4;
    localparam int DSP_NO = 64;
    localparam int WIDTH  = 16;
    localparam int LANES  = 8;
    localparam int BEATS  = 8;
    localparam int ADDR_W = 7;
`ifdef WR_PARITY_EN
    localparam int DW = LANES * WIDTH + 1;
`else
    localparam int DW = LANES * WIDTH;
`endif

    logic              clk, rst, conv1_sample, conv1_finish;
    logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
    logic              wr_en, ram_feedback, done, overrun, short_frame;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;

    int n_cmp = 0;
    int n_err = 0;

    conv1_ofm_writer #(
        .WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .conv1_sample(conv1_sample), .conv1_finish(conv1_finish),
        .ofm(ofm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_feedback(ram_feedback), .done(done), .overrun(overrun), .short_frame(short_frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        conv1_sample = 1'b0;
        conv1_finish = 1'b0;
        for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Presents one pixel (channel i = base+i) and checks its BEATS writes; an extra
    // sample with garbage ofm is injected for the edge following beat dup_at.
    task automatic send_pixel(input int base, input int addr0, input int dup_at, input bit last);
        logic [LANES*WIDTH-1:0] d;
        logic [DW-1:0]          exp;
        for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'(base + i);
        conv1_sample = 1'b1;
        step();
        conv1_sample = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            for (int l = 0; l < LANES; l++) d[l*WIDTH +: WIDTH] = 16'(base + b * LANES + l);
`ifdef WR_PARITY_EN
            exp = {^d, d};
`else
            exp = d;
`endif
            check("wr_en", wr_en, 1);
            check("wr_addr", wr_addr, addr0 + b);
            check("wr_data", wr_data, exp);
            if (base == 0 && b == 0)
                check("beat0_hand", wr_data[127:0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
            if (b == dup_at) begin
                conv1_sample = 1'b1;
                for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'hdead;
            end
            step();
            conv1_sample = 1'b0;
        end
        check("wr_en_off", wr_en, 0);
        check("ram_feedback", ram_feedback, last);
        check("done", done, last);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_short", short_frame, 0);

        // Single pixel, then a second one 28 cycles after the first
        send_pixel(0, 0, -1, 1'b0);
        check("p1_overrun", overrun, 0);
        check("p1_short", short_frame, 0);
        repeat (19) step();
        send_pixel(1000, 8, -1, 1'b0);
        check("p2_overrun", overrun, 0);

        // Second sample 4 cycles after the first is dropped
        do_reset();
        send_pixel(0, 0, 3, 1'b0);
        check("dup_overrun", overrun, 1);
        send_pixel(2000, 8, -1, 1'b0);

        // Sample coincident with the last beat is dropped
        do_reset();
        send_pixel(0, 0, 7, 1'b0);
        check("last_beat_overrun", overrun, 1);
        send_pixel(500, 8, -1, 1'b0);

        // Full WOUT=4 frame, samples spaced 10 cycles
        do_reset();
        for (int p = 0; p < WOUT * WOUT; p++) begin
            send_pixel(p * 64, p * BEATS, -1, p == WOUT * WOUT - 1);
            step();
        end
        check("rf_one_cycle", ram_feedback, 0);
        check("done_held", done, 1);
        check("frame_overrun", overrun, 0);
        conv1_sample = 1'b1;
        step();
        conv1_sample = 1'b0;
        check("done_no_write", wr_en, 0);
        check("done_overrun", overrun, 1);
        check("done_addr_hold", wr_addr, 127);
        check("done_still", done, 1);

        // Early conv1_finish flags a short frame
        do_reset();
        for (int p = 0; p < 5; p++) send_pixel(p * 64, p * BEATS, -1, 1'b0);
        check("short_before", short_frame, 0);
        conv1_finish = 1'b1;
        step();
        conv1_finish = 1'b0;
        check("short_set", short_frame, 1);
        check("short_done", done, 0);

        // Asynchronous reset during a write beat
        do_reset();
        for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'(i);
        conv1_sample = 1'b1;
        step();
        conv1_sample = 1'b0;
        step();
        check("mid_wr_en", wr_en, 1);
        rst = 1'b0;
        #1;
        check("async_wr_en", wr_en, 0);
        check("async_addr", wr_addr, 0);
        rst = 1'b1;
        step();
        send_pixel(3000, 0, -1, 1'b0);

`ifdef WR_PARITY_EN
        // Parity: eight channels of 16'h0001 give 0; one flipped bit in beat 1 gives 1
        do_reset();
        for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'h0001;
        ofm[8] = 16'h0003;
        conv1_sample = 1'b1;
        step();
        conv1_sample = 1'b0;
        check("parity_even", wr_data[LANES*WIDTH], 0);
        step();
        check("parity_odd", wr_data[LANES*WIDTH], 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv1_ofm_writer.md
Name: conv1_ofm_writer

Overview:
- Downstream of conv1; consumes each 64-channel output pixel presented on ofm with the conv1_sample strobe.
- Serialises each pixel into LANES-channel beats and writes them to the layer-1 feature-map RAM at sequential addresses.
- After the full WOUT x WOUT frame it pulses ram_feedback back to conv1 and holds done for the next layer.

Parameters:
- WOUT, 128, output feature-map width and height (frame = WOUT*WOUT pixels)
- DSP_NO, 64, channels per pixel on ofm
- WIDTH, 16, bits per channel
- LANES, 8, channels per RAM word; DSP_NO mod LANES = 0; BEATS = DSP_NO/LANES
- ADDR_W, $clog2(WOUT*WOUT*BEATS), RAM address width (17 at defaults)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- conv1_sample  in  1  one-cycle strobe: ofm valid this cycle
- conv1_finish  in  1  level from conv1: layer ended
- ofm  in  [WIDTH-1:0] x DSP_NO (unpacked [0:DSP_NO-1])  pixel channels
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM word address
- wr_data  out  LANES*WIDTH (+1 with WR_PARITY_EN)  RAM write data
- ram_feedback  out  1  one-cycle pulse when frame fully written
- done  out  1  frame complete, held until reset
- overrun  out  1  sticky: sample arrived while busy or after done
- short_frame  out  1  sticky: conv1_finish while idle with pixel count < WOUT*WOUT

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; pixel and beat counters 0; shadow register cleared.
- FSM states: IDLE, WRITE, DONE.
- IDLE: when conv1_sample=1, latch all DSP_NO channels into the shadow register, set beat=0, go to WRITE.
- WRITE: one beat per cycle.
  - wr_en=1; wr_addr = pix*BEATS + beat.
  - wr_data = shadow channels [beat*LANES .. beat*LANES+LANES-1], lowest channel in the LSBs.
  - First beat is on the cycle after the sample. The pixel occupies BEATS consecutive cycles.
- End of a beat run:
  - After beat BEATS-1: pix increments.
  - If pix was WOUT*WOUT-1: go to DONE, with ram_feedback=1 for exactly that cycle and done=1 from the same cycle.
  - Otherwise return to IDLE.
  - A sample coincident with the last beat is NOT accepted.
- conv1_sample while in WRITE: dropped, overrun set; the current pixel completes unaffected.
- DONE: wr_en=0; samples ignored and set overrun; stays until reset.
- Address arithmetic: wr_addr never wraps within a frame; maximum is WOUT*WOUT*BEATS-1.
- short_frame: set if conv1_finish=1 in IDLE and pix < WOUT*WOUT. conv1_finish has no other effect. It is ignored in WRITE and DONE.
- wr_en, wr_addr and wr_data are registered; outputs are stable for the whole cycle wr_en=1.
- Reset mid-frame: FSM returns to IDLE, the frame is abandoned, counters restart at 0, and RAM contents are not cleared.
- Minimum sample spacing for lossless operation is BEATS+1 cycles; conv1 spacing (28 cycles) satisfies this.

Optional Feature:
- Macro: WR_PARITY_EN.
- Defined: wr_data gains an extra MSB holding the even parity (XOR) of the LANES*WIDTH data bits of that beat.
- Undefined: wr_data is exactly LANES*WIDTH bits; no parity logic.

Test Plan:
- Reset then a single sample with ofm[i]=i -> 8 writes at addr 0..7 on cycles +1..+8. Beat 0 data = {16'd7,...,16'd0}. Beat 7 holds channels 56..63. No flags.
- Two samples 28 cycles apart -> second pixel written at addr 8..15; pix=2; overrun=0.
- Second sample 4 cycles after the first -> first pixel's 8 writes complete intact; second sample dropped; overrun=1; next accepted pixel lands at addr 8.
- WOUT=4 build, 16 samples spaced 10 cycles -> last write at addr 127. ram_feedback high for 1 cycle with that write's completion; done=1 held. A 17th sample sets overrun with no write.
- conv1_finish after 5 pixels (WOUT=4) -> short_frame=1, done=0. rst=0 during a WRITE beat -> wr_en drops immediately; next sample writes at addr 0.
- WR_PARITY_EN defined, beat data all 16'h0001 -> parity bit 0. Flip one bit -> parity bit 1.
